// File: rtl/dsa_debug_pkg.sv
// Shared types and readout helpers for the bilinear DSA trace capture unit.
package dsa_debug_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    TrigImmediate = 2'd0,
    TrigXy        = 2'd1,
    TrigState     = 2'd2,
    TrigNever     = 2'd3
  } trig_mode_e;

  // mem_addr is held zero-extended to 32 bits so the entry is independent of ADDR_WIDTH
  typedef struct packed {
    logic [3:0]  fsm_state;
    logic        mode_simd;
    logic        mem_wr;
    logic        mem_rd;
    logic [15:0] y;
    logic [15:0] x;
    logic [31:0] nbr;
    logic [31:0] coef;
    logic [7:0]  pixel_out;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
  } trace_entry_t;

  localparam int unsigned EntryWidth = $bits(trace_entry_t);

  localparam logic [2:0] DBG_W_STATUS = 3'd0;
  localparam logic [2:0] DBG_W_XY     = 3'd1;
  localparam logic [2:0] DBG_W_NBR    = 3'd2;
  localparam logic [2:0] DBG_W_COEF   = 3'd3;
  localparam logic [2:0] DBG_W_PIXEL  = 3'd4;
  localparam logic [2:0] DBG_W_MADDR  = 3'd5;
  localparam logic [2:0] DBG_W_MDATA  = 3'd6;

  function automatic logic [31:0] dbg_word(input trace_entry_t e, input logic [2:0] w);
    logic [31:0] r;
    r = '0;
    case (w)
      DBG_W_STATUS: r = {24'd0, e.fsm_state, e.mode_simd, e.mem_wr, e.mem_rd, 1'b0};
      DBG_W_XY:     r = {e.y, e.x};
      DBG_W_NBR:    r = e.nbr;
      DBG_W_COEF:   r = e.coef;
      DBG_W_PIXEL:  r = {24'd0, e.pixel_out};
      DBG_W_MADDR:  r = e.mem_addr;
      DBG_W_MDATA:  r = {24'd0, e.mem_data};
      default:      r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dsa_trace_mem.sv
// Trace entry RAM: one write port, one synchronous read port (read-before-write).
module dsa_trace_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dsa_debug_trace.sv
// Trigger-qualified circular trace buffer for the bilinear DSA, read back word by word
// over the debug path.
module dsa_debug_trace
  import dsa_debug_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned SIMD_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  mode_simd,
  input  logic [3:0]                                            fsm_state_seq,
  input  logic [3:0]                                            fsm_state_simd,
  input  logic [15:0]                                           current_x,
  input  logic [15:0]                                           current_y,
  input  logic [31:0]                                           seq_nbr,
  input  logic [31:0]                                           seq_coef,
  input  logic [7:0]                                            pixel_out_seq,
  input  logic [32*SIMD_WIDTH-1:0]                              simd_nbr,
  input  logic [32*SIMD_WIDTH-1:0]                              simd_coef,
  input  logic [8*SIMD_WIDTH-1:0]                               pixel_out_simd,
  input  logic [((SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1)-1:0] lane_sel,
  input  logic [ADDR_WIDTH-1:0]                                 mem_addr,
  input  logic [7:0]                                            mem_data,
  input  logic                                                  mem_read_en,
  input  logic                                                  mem_write_en,
  input  logic                                                  sample_strobe,
  input  logic                                                  arm,
  input  logic                                                  abort,
  input  logic [1:0]                                            trig_mode,
  input  logic [15:0]                                           trig_x,
  input  logic [15:0]                                           trig_y,
  input  logic [3:0]                                            trig_state,
  input  logic [$clog2(DEPTH)-1:0]                              post_count,
  input  logic [$clog2(DEPTH)-1:0]                              rd_index,
  input  logic [2:0]                                            rd_word,
  output logic [31:0]                                           rd_data,
  output logic [1:0]                                            state,
  output logic                                                  triggered,
  output logic [$clog2(DEPTH):0]                                count,
  output logic [$clog2(DEPTH)-1:0]                              trig_pos
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [IdxW:0]   FullCount = (IdxW + 1)'(DEPTH);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(DEPTH - 1);
  localparam logic [IdxW-1:0] OneIdx    = IdxW'(1);

  // Source selection
  logic [31:0] lane_ext;
  logic [31:0] sel_nbr;
  logic [31:0] sel_coef;
  logic [7:0]  sel_pix;
  logic [3:0]  sel_state;

  assign lane_ext = 32'(lane_sel);

  // Lane 0 is the default, so out-of-range lane_sel falls back to it
  always_comb begin
    sel_nbr   = simd_nbr[31:0];
    sel_coef  = simd_coef[31:0];
    sel_pix   = pixel_out_simd[7:0];
    sel_state = fsm_state_simd;
    for (int unsigned i = 1; i < SIMD_WIDTH; i++) begin
      if (lane_ext == 32'(i)) begin
        sel_nbr  = simd_nbr[32*i +: 32];
        sel_coef = simd_coef[32*i +: 32];
        sel_pix  = pixel_out_simd[8*i +: 8];
      end
    end
    if (!mode_simd) begin
      sel_nbr   = seq_nbr;
      sel_coef  = seq_coef;
      sel_pix   = pixel_out_seq;
      sel_state = fsm_state_seq;
    end
  end

  trace_entry_t wr_entry;

  always_comb begin
    wr_entry           = '0;
    wr_entry.fsm_state = sel_state;
    wr_entry.mode_simd = mode_simd;
    wr_entry.mem_wr    = mem_write_en;
    wr_entry.mem_rd    = mem_read_en;
    wr_entry.y         = current_y;
    wr_entry.x         = current_x;
    wr_entry.nbr       = sel_nbr;
    wr_entry.coef      = sel_coef;
    wr_entry.pixel_out = sel_pix;
    wr_entry.mem_addr  = 32'(mem_addr);
    wr_entry.mem_data  = mem_data;
  end

  logic trig_hit;

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_e'(trig_mode))
      TrigImmediate: trig_hit = 1'b1;
      TrigXy:        trig_hit = (current_x == trig_x) && (current_y == trig_y);
      TrigState:     trig_hit = (sel_state == trig_state);
      default:       trig_hit = 1'b0;
    endcase
  end

  // Capture control
  trace_state_e    state_q, state_d;
  logic [IdxW:0]   count_q, count_d;
  logic [IdxW-1:0] wptr_q, wptr_d;
  logic [IdxW-1:0] trig_pos_q, trig_pos_d;
  logic [IdxW-1:0] rem_q, rem_d;
  logic            trig_q, trig_d;
  logic            full;
  logic            we;

  assign full = (count_q == FullCount);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    trig_pos_d = trig_pos_q;
    rem_d      = rem_q;
    trig_d     = trig_q;
    we         = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else if (arm) begin
      state_d    = StArmed;
      count_d    = '0;
      wptr_d     = '0;
      trig_pos_d = '0;
      rem_d      = '0;
      trig_d     = 1'b0;
    end else if (sample_strobe && (state_q == StArmed || state_q == StPost)) begin
      we     = 1'b1;
      wptr_d = wptr_q + 1'b1;
      if (!full) begin
        count_d = count_q + 1'b1;
      end
      // Overwriting the oldest entry shifts every logical index down by one
      if (trig_q && full) begin
        trig_pos_d = (trig_pos_q == '0) ? '0 : trig_pos_q - 1'b1;
      end
      if (state_q == StArmed) begin
        if (trig_hit) begin
          trig_d     = 1'b1;
          trig_pos_d = full ? LastIdx : count_q[IdxW-1:0];
          if (post_count == '0) begin
            state_d = StDone;
          end else begin
            rem_d   = post_count;
            state_d = StPost;
          end
        end
      end else begin
        rem_d = rem_q - 1'b1;
        if (rem_q == OneIdx) begin
          state_d = StDone;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      wptr_q     <= '0;
      trig_pos_q <= '0;
      rem_q      <= '0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      trig_pos_q <= trig_pos_d;
      rem_q      <= rem_d;
      trig_q     <= trig_d;
    end
  end

  assign state     = state_q;
  assign triggered = trig_q;
  assign count     = count_q;
  assign trig_pos  = trig_pos_q;

  // Readout: logical index 0 is the oldest entry
  logic [IdxW-1:0]       rd_addr;
  logic [EntryWidth-1:0] rd_raw;
  logic                  rd_valid_q;
  logic [2:0]            rd_word_q;

  assign rd_addr = wptr_q - count_q[IdxW-1:0] + rd_index;

  dsa_trace_mem #(
    .DEPTH(DEPTH),
    .WIDTH(EntryWidth)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wptr_q),
    .wdata(wr_entry),
    .raddr(rd_addr),
    .rdata(rd_raw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_word_q  <= '0;
    end else begin
      rd_valid_q <= ({1'b0, rd_index} < count_q);
      rd_word_q  <= rd_word;
    end
  end

  assign rd_data = rd_valid_q ? dbg_word(trace_entry_t'(rd_raw), rd_word_q) : '0;

endmodule

// File: doc/dsa_debug_trace.md
# dsa_debug_trace

Parametrised trace capture unit for the bilinear-interpolation DSA. On each step strobe it records a snapshot of FSM state, coordinates, neighbour pixels, coefficients, output pixel and memory-bus activity into a circular buffer of DEPTH entries. Recording is trigger-qualified, with a programmable post-trigger window. The buffer is read back word by word over the JTAG debug path. It sits beside `dsa_top` and generalises the single-snapshot debug registers to any lane count and to a history of snapshots.

## Interface
- `ADDR_WIDTH`, 18: memory address width.
- `SIMD_WIDTH`, 4: lane count, ≥1.
- `DEPTH`, 16: trace entries; must be a power of two, ≥2.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous reset, active-high.
- `mode_simd` in 1: 1 selects SIMD sources, 0 selects sequential sources.
- `fsm_state_seq`, `fsm_state_simd` in 4 each: FSM states.
- `current_x`, `current_y` in 16 each: output coordinates.
- `seq_nbr` in 32: sequential neighbours {p11,p10,p01,p00}.
- `seq_coef` in 32: sequential coefficients {b,a}.
- `pixel_out_seq` in 8: sequential output pixel.
- `simd_nbr` in 32·SIMD_WIDTH: per lane, same packing; lane i at [32i+:32].
- `simd_coef` in 32·SIMD_WIDTH: per lane {b,a}.
- `pixel_out_simd` in 8·SIMD_WIDTH: lane i at [8i+:8].
- `lane_sel` in max(1,$clog2(SIMD_WIDTH)): SIMD lane to record.
- `mem_addr` in ADDR_WIDTH; `mem_data` in 8; `mem_read_en`, `mem_write_en` in 1.
- `sample_strobe` in 1: step_ack pulse; one sample per high cycle.
- `arm`, `abort` in 1: control pulses.
- `trig_mode` in 2: 0 = immediate; 1 = x/y match; 2 = state match; 3 = never (free-run).
- `trig_x`, `trig_y` in 16 each; `trig_state` in 4: trigger compare values.
- `post_count` in $clog2(DEPTH): samples recorded after the trigger sample.
- `rd_index` in $clog2(DEPTH): 0 = oldest entry.
- `rd_word` in 3: word within the entry.
- `rd_data` out 32: readout.
- `state` out 2; `triggered` out 1; `count` out $clog2(DEPTH)+1; `trig_pos` out $clog2(DEPTH): logical index of the trigger entry.

## Operation
- Recorded state is the state mux selected by `mode_simd`.
- Data source is sequential when `mode_simd`=0, otherwise lane `lane_sel`.
- `lane_sel` ≥ SIMD_WIDTH records lane 0.
- Entry readout words:
  - 0: {24'd0, state, mode_simd, mem_wr, mem_rd, 1'b0}
  - 1: {y,x}
  - 2: nbr
  - 3: coef
  - 4: {24'd0, pixel_out}
  - 5: zero-extended mem_addr
  - 6: {24'd0, mem_data}
  - 7: 0
- States:
  - IDLE: no recording.
  - ARMED: record every strobe. If the strobe sample matches the trigger: `triggered`←1, `trig_pos` set, remaining←`post_count`. Go to DONE if `post_count`=0, otherwise POST.
  - POST: record every strobe and decrement remaining; go to DONE when the sample that makes remaining reach 0 is recorded.
  - DONE: hold buffer, no writes.
  - Mode 3 never leaves ARMED.
- Trigger matches compare the live inputs of the strobe cycle.
- `arm` from any state clears `count`, the write pointer, `triggered` and `trig_pos`, then enters ARMED.
- `abort` enters IDLE with the buffer retained.
- Same-cycle priority is `abort` > `arm` > `sample_strobe`. The losing strobe is dropped.
- Write pointer wraps modulo DEPTH. `count` saturates at DEPTH, and the oldest entry is overwritten once full. `trig_pos` is adjusted so it keeps pointing at the same physical entry; if the trigger entry is overwritten, `trig_pos` saturates at 0.
- Physical read address = (wptr − count + rd_index) mod DEPTH.
- `rd_index` ≥ `count` reads as 0.

## Timing
- Reset: state IDLE; `rd_data`, `triggered`, `count`, `trig_pos` all 0; pointers 0; entry contents undefined.
- Strobe at cycle N: entry is written at edge N. `count`, `state`, `triggered` update at edge N and are visible in cycle N+1.
- `rd_data` is registered with 1-cycle latency: index/word in cycle N gives data in cycle N+1.
- A read of the entry being written at edge N returns the new data from cycle N+2.
- Reads are legal in every state.
- Reset mid-POST returns everything to reset values.

## Structure
- Package `dsa_debug_pkg` holds:
  - `trace_state_e` {IDLE, ARMED, POST, DONE}
  - `trig_mode_e`
  - `trace_entry_t` packed struct
  - word-index constants `DBG_W_STATUS` through `DBG_W_MDATA`
- Sub-module `dsa_trace_mem`: DEPTH × entry RAM with one write port and one synchronous read port.

## Test plan
- Reset, `arm`, mode 0, strobe with x=5, y=7 → DONE after 1 cycle with `post_count`=0; `count`=1; word1 reads 0x00070005.
- Mode 1, trig (3,3), `post_count`=2, strobe x=0..5, y=3 → DONE, `count`=6, `trig_pos`=3, index 5 word1 = 0x00030005.
- Mode 3, DEPTH=16, 20 strobes x=0..19 → `count`=16, index 0 x=4, index 15 x=19, state ARMED.
- `mode_simd`=1, `lane_sel`=2, lane2 nbr 0x44332211, out 0xAB → word2 0x44332211, word4 0x000000AB.
- `arm` and `sample_strobe` in the same cycle → `count` 0. `abort`+`arm` → IDLE, buffer retained.
- `rd_index`=`count` → `rd_data` 0; `rst` asserted in POST → all outputs 0, IDLE.
